// File: rtl/ddr_read_arbiter.sv
// Round-robin arbiter sharing one DDR burst-read port between the ISA refill
// path and the DAT load path. Returned beats are steered to the granted requester.
module ddr_read_arbiter #(
    parameter int DDR_ADDR_WIDTH = 28,
    parameter int DDR_DATA_WIDTH = 64,
    parameter int ISA_WIDTH      = 30,
    parameter int LEN_WIDTH      = 10
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      isa_req,
    input  logic [DDR_ADDR_WIDTH-1:0] isa_addr,
    input  logic [LEN_WIDTH-1:0]      isa_len,
    output logic [ISA_WIDTH-1:0]      isa_data,
    output logic                      isa_data_valid,
    output logic [LEN_WIDTH-1:0]      isa_rd_cnt,
    output logic                      isa_done,
    input  logic                      dat_req,
    input  logic [DDR_ADDR_WIDTH-1:0] dat_addr,
    input  logic [LEN_WIDTH-1:0]      dat_len,
    output logic [DDR_DATA_WIDTH-1:0] dat_data,
    output logic                      dat_data_valid,
    output logic [LEN_WIDTH-1:0]      dat_rd_cnt,
    output logic                      dat_done,
    input  logic                      ddr_rdy,
    output logic                      rd_burst_req,
    output logic [DDR_ADDR_WIDTH-1:0] rd_burst_addr,
    output logic [LEN_WIDTH-1:0]      rd_burst_len,
    input  logic [DDR_DATA_WIDTH-1:0] rd_burst_data,
    input  logic                      rd_burst_data_valid,
    input  logic                      rd_burst_finish,
    output logic                      owner,
    output logic                      busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, DATA, DONE} state_t;

    state_t state;
    logic   last_grant;
    logic   isa_win;

    // On contention the requester that did not win last time goes first.
    always_comb begin
        isa_win = isa_req && (!dat_req || last_grant);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            last_grant     <= 1'b1;
            owner          <= 1'b0;
            busy           <= 1'b0;
            rd_burst_req   <= 1'b0;
            rd_burst_addr  <= '0;
            rd_burst_len   <= '0;
            isa_data       <= '0;
            isa_data_valid <= 1'b0;
            isa_rd_cnt     <= '0;
            isa_done       <= 1'b0;
            dat_data       <= '0;
            dat_data_valid <= 1'b0;
            dat_rd_cnt     <= '0;
            dat_done       <= 1'b0;
        end else begin
            isa_data_valid <= 1'b0;
            dat_data_valid <= 1'b0;
            isa_done       <= 1'b0;
            dat_done       <= 1'b0;
            case (state)
                IDLE: begin
                    if (ddr_rdy && (isa_req || dat_req)) begin
                        state <= ISSUE;
                        busy  <= 1'b1;
                        if (isa_win) begin
                            owner         <= 1'b0;
                            last_grant    <= 1'b0;
                            rd_burst_addr <= isa_addr;
                            rd_burst_len  <= isa_len;
                            isa_rd_cnt    <= '0;
                        end else begin
                            owner         <= 1'b1;
                            last_grant    <= 1'b1;
                            rd_burst_addr <= dat_addr;
                            rd_burst_len  <= dat_len;
                            dat_rd_cnt    <= '0;
                        end
                    end
                end
                ISSUE: begin
                    // A zero-length burst never touches the DDR interface.
                    if (rd_burst_len == '0) begin
                        state <= DONE;
                        if (owner) dat_done <= 1'b1;
                        else       isa_done <= 1'b1;
                    end else begin
                        rd_burst_req <= 1'b1;
                        state        <= DATA;
                    end
                end
                DATA: begin
                    if (rd_burst_data_valid) begin
                        if (!owner && isa_rd_cnt < rd_burst_len) begin
                            isa_data       <= rd_burst_data[ISA_WIDTH-1:0];
                            isa_data_valid <= 1'b1;
                            isa_rd_cnt     <= isa_rd_cnt + LEN_WIDTH'(1);
                        end
                        if (owner && dat_rd_cnt < rd_burst_len) begin
                            dat_data       <= rd_burst_data;
                            dat_data_valid <= 1'b1;
                            dat_rd_cnt     <= dat_rd_cnt + LEN_WIDTH'(1);
                        end
                    end
                    if (rd_burst_finish) begin
                        rd_burst_req <= 1'b0;
                        state        <= DONE;
                        if (owner) dat_done <= 1'b1;
                        else       isa_done <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ddr_read_arbiter.sv
// Directed bench for ddr_read_arbiter: the bench plays both requesters and the
// DDR interface, checking every output against hand-computed values.
module tb_ddr_read_arbiter;

    localparam int AW = 28;
    localparam int DW = 64;
    localparam int IW = 30;
    localparam int LW = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          isa_req = 1'b0;
    logic [AW-1:0] isa_addr = '0;
    logic [LW-1:0] isa_len = '0;
    logic [IW-1:0] isa_data;
    logic          isa_data_valid;
    logic [LW-1:0] isa_rd_cnt;
    logic          isa_done;
    logic          dat_req = 1'b0;
    logic [AW-1:0] dat_addr = '0;
    logic [LW-1:0] dat_len = '0;
    logic [DW-1:0] dat_data;
    logic          dat_data_valid;
    logic [LW-1:0] dat_rd_cnt;
    logic          dat_done;
    logic          ddr_rdy = 1'b0;
    logic          rd_burst_req;
    logic [AW-1:0] rd_burst_addr;
    logic [LW-1:0] rd_burst_len;
    logic [DW-1:0] rd_burst_data = '0;
    logic          rd_burst_data_valid = 1'b0;
    logic          rd_burst_finish = 1'b0;
    logic          owner;
    logic          busy;

    int n_checks = 0;
    int n_fail   = 0;
    logic [DW-1:0] beat;

    ddr_read_arbiter dut (
        .clk(clk), .rst(rst),
        .isa_req(isa_req), .isa_addr(isa_addr), .isa_len(isa_len),
        .isa_data(isa_data), .isa_data_valid(isa_data_valid),
        .isa_rd_cnt(isa_rd_cnt), .isa_done(isa_done),
        .dat_req(dat_req), .dat_addr(dat_addr), .dat_len(dat_len),
        .dat_data(dat_data), .dat_data_valid(dat_data_valid),
        .dat_rd_cnt(dat_rd_cnt), .dat_done(dat_done),
        .ddr_rdy(ddr_rdy), .rd_burst_req(rd_burst_req),
        .rd_burst_addr(rd_burst_addr), .rd_burst_len(rd_burst_len),
        .rd_burst_data(rd_burst_data), .rd_burst_data_valid(rd_burst_data_valid),
        .rd_burst_finish(rd_burst_finish), .owner(owner), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives the DDR return side for the next clock edge.
    task automatic applyStimulus(input logic v, input logic [DW-1:0] d, input logic fin);
        rd_burst_data_valid = v;
        rd_burst_data       = d;
        rd_burst_finish     = fin;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " busy"}, busy, 0);
        checkOutput({tag, " owner"}, owner, 0);
        checkOutput({tag, " rd_burst_req"}, rd_burst_req, 0);
        checkOutput({tag, " rd_burst_addr"}, rd_burst_addr, 0);
        checkOutput({tag, " rd_burst_len"}, rd_burst_len, 0);
        checkOutput({tag, " isa_rd_cnt"}, isa_rd_cnt, 0);
        checkOutput({tag, " isa_valid"}, isa_data_valid, 0);
        checkOutput({tag, " isa_data"}, isa_data, 0);
        checkOutput({tag, " isa_done"}, isa_done, 0);
        checkOutput({tag, " dat_rd_cnt"}, dat_rd_cnt, 0);
        checkOutput({tag, " dat_valid"}, dat_data_valid, 0);
        checkOutput({tag, " dat_data"}, dat_data, 0);
        checkOutput({tag, " dat_done"}, dat_done, 0);
    endtask

    initial begin
        // Reset values
        rst = 1'b0;
        tick();
        checkAllZero("reset");
        tick();
        rst = 1'b1;
        ddr_rdy = 1'b1;

        // Single ISA burst of 4 beats
        isa_req = 1'b1; isa_addr = 28'h400; isa_len = 10'd4;
        tick();
        checkOutput("t1 grant busy", busy, 1);
        checkOutput("t1 grant owner", owner, 0);
        checkOutput("t1 no req yet", rd_burst_req, 0);
        checkOutput("t1 addr", rd_burst_addr, 28'h400);
        checkOutput("t1 len", rd_burst_len, 4);
        tick();
        checkOutput("t1 burst req", rd_burst_req, 1);
        for (int k = 1; k <= 4; k++) begin
            beat = 64'hA5A5_0000_0000_0000 | 64'(k * 32'h1111_1111);
            applyStimulus(1'b1, beat, k == 4);
            tick();
            checkOutput("t1 isa valid", isa_data_valid, 1);
            checkOutput("t1 isa data", isa_data, {34'd0, beat[IW-1:0]});
            checkOutput("t1 isa cnt", isa_rd_cnt, k);
            checkOutput("t1 isa done", isa_done, (k == 4) ? 1 : 0);
            checkOutput("t1 dat valid", dat_data_valid, 0);
        end
        applyStimulus(1'b0, '0, 1'b0);
        isa_req = 1'b0;
        checkOutput("t1 req dropped", rd_burst_req, 0);
        checkOutput("t1 busy in done", busy, 1);
        tick();
        checkOutput("t1 done single", isa_done, 0);
        checkOutput("t1 busy idle", busy, 0);
        checkOutput("t1 dat cnt", dat_rd_cnt, 0);
        checkOutput("t1 dat done", dat_done, 0);

        // Contention: ISA first, then DAT, then ISA
        rst = 1'b0;
        tick();
        rst = 1'b1;
        isa_req = 1'b1; isa_addr = 28'h100; isa_len = 10'd2;
        dat_req = 1'b1; dat_addr = 28'h200; dat_len = 10'd1;
        tick();
        checkOutput("t2 first owner", owner, 0);
        checkOutput("t2 first addr", rd_burst_addr, 28'h100);
        tick();
        applyStimulus(1'b1, 64'h1, 1'b0);
        tick();
        checkOutput("t2 isa cnt1", isa_rd_cnt, 1);
        applyStimulus(1'b1, 64'h2, 1'b1);
        tick();
        checkOutput("t2 isa cnt2", isa_rd_cnt, 2);
        checkOutput("t2 isa done", isa_done, 1);
        applyStimulus(1'b0, '0, 1'b0);
        tick();
        checkOutput("t2 idle busy", busy, 0);
        tick();
        checkOutput("t2 second owner", owner, 1);
        checkOutput("t2 second addr", rd_burst_addr, 28'h200);
        checkOutput("t2 second len", rd_burst_len, 1);
        tick();
        checkOutput("t2 dat burst req", rd_burst_req, 1);
        applyStimulus(1'b1, 64'hDEAD_BEEF_CAFE_F00D, 1'b1);
        tick();
        checkOutput("t2 dat valid", dat_data_valid, 1);
        checkOutput("t2 dat data", dat_data, 64'hDEAD_BEEF_CAFE_F00D);
        checkOutput("t2 dat cnt", dat_rd_cnt, 1);
        checkOutput("t2 dat done", dat_done, 1);
        checkOutput("t2 isa quiet", isa_data_valid, 0);
        checkOutput("t2 isa cnt hold", isa_rd_cnt, 2);
        applyStimulus(1'b0, '0, 1'b0);
        tick();
        tick();
        checkOutput("t2 third owner", owner, 0);
        checkOutput("t2 isa cnt clr", isa_rd_cnt, 0);
        checkOutput("t2 dat cnt hold", dat_rd_cnt, 1);
        isa_req = 1'b0; dat_req = 1'b0;
        tick();
        applyStimulus(1'b0, '0, 1'b1);
        tick();
        checkOutput("t2 empty done", isa_done, 1);
        applyStimulus(1'b0, '0, 1'b0);
        tick();

        // Zero-length DAT burst
        dat_req = 1'b1; dat_addr = 28'h300; dat_len = 10'd0;
        tick();
        checkOutput("t3 owner", owner, 1);
        checkOutput("t3 cnt clr", dat_rd_cnt, 0);
        tick();
        checkOutput("t3 done", dat_done, 1);
        checkOutput("t3 no burst", rd_burst_req, 0);
        dat_req = 1'b0;
        tick();
        checkOutput("t3 done once", dat_done, 0);
        checkOutput("t3 idle", busy, 0);

        // ISA len 3, DDR returns 5 beats
        isa_req = 1'b1; isa_addr = 28'h500; isa_len = 10'd3;
        tick();
        tick();
        for (int k = 1; k <= 5; k++) begin
            applyStimulus(1'b1, 64'(k), k == 5);
            tick();
            checkOutput("t4 valid", isa_data_valid, (k <= 3) ? 1 : 0);
            checkOutput("t4 cnt", isa_rd_cnt, (k <= 3) ? k : 3);
            checkOutput("t4 done", isa_done, (k == 5) ? 1 : 0);
            checkOutput("t4 req", rd_burst_req, (k == 5) ? 0 : 1);
        end
        checkOutput("t4 last data", isa_data, 3);
        applyStimulus(1'b0, '0, 1'b0);
        isa_req = 1'b0;
        tick();

        // DDR not ready blocks the grant
        ddr_rdy = 1'b0;
        isa_req = 1'b1; isa_addr = 28'h600; isa_len = 10'd1;
        for (int k = 0; k < 10; k++) begin
            tick();
            checkOutput("t5 no grant", busy, 0);
        end
        ddr_rdy = 1'b1;
        tick();
        checkOutput("t5 grant", busy, 1);
        checkOutput("t5 addr", rd_burst_addr, 28'h600);
        isa_req = 1'b0;
        tick();
        applyStimulus(1'b1, 64'h77, 1'b1);
        tick();
        checkOutput("t5 done", isa_done, 1);
        applyStimulus(1'b0, '0, 1'b0);
        tick();

        // Reset mid-burst, then a full 8-beat burst
        isa_req = 1'b1; isa_addr = 28'h800; isa_len = 10'd8;
        tick();
        tick();
        for (int k = 1; k <= 2; k++) begin
            applyStimulus(1'b1, 64'(k + 16), 1'b0);
            tick();
            checkOutput("t6 pre cnt", isa_rd_cnt, k);
        end
        applyStimulus(1'b0, '0, 1'b0);
        rst = 1'b0;
        #1;
        checkAllZero("t6 async reset");
        tick();
        rst = 1'b1;
        tick();
        checkOutput("t6 regrant", busy, 1);
        checkOutput("t6 regrant len", rd_burst_len, 8);
        tick();
        checkOutput("t6 burst req", rd_burst_req, 1);
        for (int k = 1; k <= 8; k++) begin
            applyStimulus(1'b1, 64'(k + 32), k == 8);
            tick();
            checkOutput("t6 valid", isa_data_valid, 1);
            checkOutput("t6 data", isa_data, k + 32);
            checkOutput("t6 cnt", isa_rd_cnt, k);
        end
        checkOutput("t6 done", isa_done, 1);
        applyStimulus(1'b0, '0, 1'b0);
        isa_req = 1'b0;
        tick();
        checkOutput("t6 idle", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
